// File: rtl/wb_wbuf.sv
// Posted-write buffer between a CPU data bus and a Wishbone arbiter port.
// Writes are acked at once and drained in order; reads wait for the drain.
module wb_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        s_cyc,
  input  logic        s_we,
  input  logic [3:0]  s_sel,
  input  logic [31:0] s_adr,
  input  logic [31:0] s_dat,
  output logic        s_ack,
  output logic [31:0] s_rdt,
  output logic        m_cyc,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat,
  input  logic        m_ack,
  input  logic [31:0] m_rdt,
  output logic        wbuf_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    GAP
  } state_t;

  state_t state, state_n;

  logic [31:0]   fifo_adr [DEPTH];
  logic [31:0]   fifo_dat [DEPTH];
  logic [3:0]    fifo_sel [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic push, pop, rd_done;

  // Acceptance looks only at the registered count and s_ack,
  // never at the FSM, so posting continues during a drain.
  assign push    = s_cyc & s_we & ~s_ack & (count != FULL);
  assign pop     = (state == WRITE) & m_ack;
  assign rd_done = (state == READ) & m_ack;

  always_ff @(posedge wb_clk) begin
    if (push) begin
      fifo_adr[wr_ptr] <= s_adr;
      fifo_dat[wr_ptr] <= s_dat;
      fifo_sel[wr_ptr] <= s_sel;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      s_ack <= 1'b0;
      s_rdt <= '0;
    end else begin
      state <= state_n;
      s_ack <= push | rd_done;
      s_rdt <= rd_done ? m_rdt : '0;
    end
  end

  always_comb begin
    state_n = state;
    m_cyc   = 1'b0;
    m_we    = 1'b0;
    m_sel   = '0;
    m_adr   = '0;
    m_dat   = '0;
    unique case (state)
      IDLE: begin
        if (count != '0)
          state_n = WRITE;
        else if (s_cyc & ~s_we & ~s_ack)
          state_n = READ;
      end
      WRITE: begin
        m_cyc = 1'b1;
        m_we  = 1'b1;
        m_sel = fifo_sel[rd_ptr];
        m_adr = fifo_adr[rd_ptr];
        m_dat = fifo_dat[rd_ptr];
        if (m_ack) state_n = GAP;
      end
      READ: begin
        m_cyc = 1'b1;
        m_adr = s_adr;
        if (m_ack) state_n = GAP;
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign wbuf_empty = (count == '0) & (state != WRITE);

endmodule

// File: tb/tb_wb_wbuf.sv
// Bench for wb_wbuf: table vectors, directed corner sequences,
// random traffic against a word-memory model and an ordered write queue.
module tb_wb_wbuf;

  localparam int DEPTH = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        s_cyc = 1'b0, s_we = 1'b0;
  logic [3:0]  s_sel = '0;
  logic [31:0] s_adr = '0, s_dat = '0;
  logic        s_ack;
  logic [31:0] s_rdt;
  logic        m_cyc, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat;
  logic        m_ack;
  logic [31:0] m_rdt;
  logic        wbuf_empty;

  wb_wbuf #(.DEPTH(DEPTH)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .s_cyc(s_cyc), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat(s_dat),
    .s_ack(s_ack), .s_rdt(s_rdt),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat(m_dat),
    .m_ack(m_ack), .m_rdt(m_rdt),
    .wbuf_empty(wbuf_empty)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] dat,
                                        logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  // Downstream slave: word memory, ack after slave_lat waiting cycles
  int slave_lat = 1;
  int lat_cnt;
  logic [31:0] smem [256];

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m_ack   <= 1'b0;
      m_rdt   <= '0;
      lat_cnt <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else if (m_cyc && !m_ack) begin
      if (lat_cnt >= slave_lat) begin
        m_ack   <= 1'b1;
        lat_cnt <= 0;
        if (m_we)
          smem[m_adr[9:2]] <= merge(smem[m_adr[9:2]], m_dat, m_sel);
        else
          m_rdt <= smem[m_adr[9:2]];
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      m_ack <= 1'b0;
      m_rdt <= '0;
    end
  end

  // Reference state: model memory and the accepted-write order
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] ref_mem [256];
  int          accepted = 0;
  int          popped = 0;
  int          pop_edge = 0;
  int          dn_cycles = 0;
  logic        prev_hold = 1'b0;
  logic [68:0] prev_bus = '0;

  always @(negedge wb_clk) begin
    if (!wb_rst_n) begin
      prev_hold = 1'b0;
      popped = 0;
      exp_q.delete();
    end else begin
      if (!m_cyc) begin
        chk("m_idle_zero", {31'd0, m_we | (|m_sel) | (|m_adr) | (|m_dat)}, 0);
        prev_hold = 1'b0;
      end else begin
        dn_cycles++;
        if (prev_hold)
          chk("m_stable", {31'd0, {m_we, m_sel, m_adr, m_dat} == prev_bus}, 1);
        if (!m_we) begin
          chk("rd_after_drain", accepted - popped, 0);
          chk("rd_sel_zero", {28'd0, m_sel}, 0);
          chk("rd_dat_zero", m_dat, 0);
          chk("rd_adr", m_adr, s_adr);
        end
        if (m_ack && m_we) begin
          popped++;
          pop_edge = cyc + 1;
          if (exp_q.size() == 0) begin
            chk("dn_unexpected_write", 0, 1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("dn_order_adr", m_adr, e.adr);
            chk("dn_order_dat", m_dat, e.dat);
            chk("dn_order_sel", {28'd0, m_sel}, {28'd0, e.sel});
          end
        end
        prev_hold = !m_ack;
        prev_bus  = {m_we, m_sel, m_adr, m_dat};
      end
      if (!s_ack) chk("s_rdt_zero_no_ack", s_rdt, 0);
      chk("count_le_depth", {31'd0, (accepted - popped) <= DEPTH}, 1);
    end
  end

  // CPU side; every task starts and ends 1 time unit after a rising edge
  task automatic cpu_write(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel,
                           output int lat, output int ack_edge);
    bit got;
    got = 0;
    lat = 0;
    ack_edge = 0;
    s_cyc = 1'b1; s_we = 1'b1; s_adr = adr; s_dat = dat; s_sel = sel;
    while (!got && lat < 200) begin
      @(posedge wb_clk); #1;
      lat++;
      if (s_ack) got = 1;
    end
    chk("wr_ack_seen", {31'd0, got}, 1);
    if (got) begin
      chk("wr_ack_rdt_zero", s_rdt, 0);
      accepted++;
      ack_edge = cyc;
      exp_q.push_back('{adr: adr, dat: dat, sel: sel});
      ref_mem[adr[9:2]] = merge(ref_mem[adr[9:2]], dat, sel);
    end
    s_cyc = 1'b0; s_we = 1'b0; s_adr = '0; s_dat = '0; s_sel = '0;
    @(posedge wb_clk); #1;
    chk("wr_ack_one_cycle", {31'd0, s_ack}, 0);
  endtask

  task automatic cpu_read(input logic [31:0] adr, output logic [31:0] d);
    bit got;
    int n;
    got = 0;
    n = 0;
    d = '0;
    s_cyc = 1'b1; s_we = 1'b0; s_adr = adr;
    while (!got && n < 400) begin
      @(posedge wb_clk); #1;
      n++;
      if (s_ack) got = 1;
    end
    chk("rd_ack_seen", {31'd0, got}, 1);
    if (got) d = s_rdt;
    s_cyc = 1'b0; s_adr = '0;
    @(posedge wb_clk); #1;
    chk("rd_ack_one_cycle", {31'd0, s_ack}, 0);
  endtask

  task automatic wait_empty(string name);
    int n;
    n = 0;
    while (!wbuf_empty && n < 300) begin
      @(posedge wb_clk); #1;
      n++;
    end
    chk(name, {31'd0, wbuf_empty}, 1);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          lat, edge_n;
    logic [31:0] d;

    vecs[0] = '{1'b1, 32'h20, 32'h1234_3456, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_3456};
    vecs[2] = '{1'b1, 32'h14, 32'hFACE_FACE, 4'hF, 32'h0};
    vecs[3] = '{1'b0, 32'h14, 32'h0, 4'h0, 32'hFACE_FACE};
    vecs[4] = '{1'b1, 32'h14, 32'h0000_00AB, 4'h1, 32'h0};
    vecs[5] = '{1'b1, 32'h14, 32'h0000_CD00, 4'h2, 32'h0};
    vecs[6] = '{1'b0, 32'h14, 32'h0, 4'h0, 32'hFACE_CDAB};
    vecs[7] = '{1'b1, 32'h18, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vecs[8] = '{1'b0, 32'h18, 32'h0, 4'h0, 32'h0};
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    #2;
    chk("rst_s_ack", {31'd0, s_ack}, 0);
    chk("rst_s_rdt", s_rdt, 0);
    chk("rst_m_cyc", {31'd0, m_cyc}, 0);
    chk("rst_m_bus", {31'd0, m_we | (|m_sel) | (|m_adr) | (|m_dat)}, 0);
    chk("rst_empty", {31'd0, wbuf_empty}, 1);
    repeat (2) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;

    slave_lat = 1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) begin
        cpu_write(vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, edge_n);
        chk($sformatf("tbl_wr_lat_%0d", i), lat, 1);
      end else begin
        cpu_read(vecs[i].adr, d);
        chk($sformatf("tbl_rd_%0d", i), d, vecs[i].exp);
      end
    end
    wait_empty("tbl_empty_after");

    // Full buffer, slow downstream: fifth write waits for the first pop
    slave_lat = 6;
    for (int i = 0; i < 5; i++) begin
      cpu_write(32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, lat, edge_n);
      if (i < 4) begin
        chk($sformatf("fill_lat_%0d", i), lat, 1);
      end else begin
        chk("stall_lat_gt1", {31'd0, lat > 1}, 1);
        chk("push_after_pop", edge_n, pop_edge + 1);
      end
    end
    wait_empty("fill_empty_after");
    chk("fill_queue_drained", exp_q.size(), 0);

    // Reset while the first of three buffered writes is on the bus
    slave_lat = 20;
    for (int i = 0; i < 3; i++)
      cpu_write(32'h300 + 32'(i * 4), 32'h5000_0000 + 32'(i), 4'hF, lat, edge_n);
    chk("mid_rst_m_cyc_before", {31'd0, m_cyc}, 1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_m_cyc_drop", {31'd0, m_cyc}, 0);
    chk("mid_rst_empty", {31'd0, wbuf_empty}, 1);
    accepted = 0;
    @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;
    begin
      int mark;
      mark = dn_cycles;
      repeat (20) @(posedge wb_clk);
      #1;
      chk("mid_rst_no_traffic", dn_cycles - mark, 0);
      chk("mid_rst_empty_after", {31'd0, wbuf_empty}, 1);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Random mix of posted writes and reads against the model memory
    for (int n = 0; n < 150; n++) begin
      logic [31:0] adr;
      slave_lat = $urandom_range(0, 3);
      adr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 9) < 7) begin
        cpu_write(adr, $urandom, 4'($urandom_range(0, 15)), lat, edge_n);
      end else begin
        cpu_read(adr, d);
        chk("rand_rd", d, ref_mem[adr[9:2]]);
      end
      repeat ($urandom_range(0, 2)) @(posedge wb_clk);
      #0;
    end
    wait_empty("rand_empty_after");
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
